// File: rtl/flash_pkg.sv
// Shared definitions for the 32-bit flash read protocol.
// Used by the flash read responder and the flash read master.
package flash_pkg;

   localparam int FLASH_DATA_W = 32;
   localparam int FLASH_ADDR_W = 21;

   typedef logic [FLASH_DATA_W-1:0] flash_word_t;

endpackage

// File: rtl/flash_resp_pipe.sv
// Valid+data shift register with asynchronous clear.
// Data is zeroed whenever its valid bit is clear.
module flash_resp_pipe
   import flash_pkg::*;
#(
   parameter int unsigned DEPTH  = 3,
   parameter int unsigned DATA_W = FLASH_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data
);

   logic [DEPTH-1:0]             r_valid;
   logic [DEPTH-1:0][DATA_W-1:0] r_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
         r_data  <= '0;
      end else begin
         r_valid[0] <= i_valid;
         r_data[0]  <= i_valid ? i_data : '0;
         for (int unsigned k = 1; k < DEPTH; k++) begin
            r_valid[k] <= r_valid[k-1];
            r_data[k]  <= r_data[k-1];
         end
      end
   end

   assign o_valid = r_valid[DEPTH-1];
   assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/flash_read_responder.sv
// Avalon-MM-style read responder backed by a synchronous ROM port.
// Fixed-latency, in-order responses with an outstanding-read limit and optional throttling.
module flash_read_responder
   import flash_pkg::*;
#(
   parameter int ADDR_W      = FLASH_ADDR_W,
   parameter int LATENCY     = 4,
   parameter int MAX_PENDING = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               flash_mem_read,
   input  logic [ADDR_W-1:0]                  flash_mem_address,
   output logic                               flash_mem_waitrequest,
   output logic                               flash_mem_readdatavalid,
   output flash_word_t                        flash_mem_readdata,
   input  logic                               throttle,
   output logic                               rom_rd,
   output logic [ADDR_W-1:0]                  rom_addr,
   input  flash_word_t                        rom_q,
   output logic [$clog2(MAX_PENDING+1)-1:0]   pending_count
);

   localparam int CNT_W = $clog2(MAX_PENDING+1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic             r_tog;
   logic             r_acc_d;
   logic [CNT_W-1:0] r_pending;
   logic             w_accept;

   // Waitrequest uses registered state only, so a same-cycle response never frees a slot.
   assign flash_mem_waitrequest = (r_pending == MAX_CNT) | (throttle & r_tog);
   assign w_accept              = flash_mem_read & ~flash_mem_waitrequest & ~reset;

   assign rom_rd        = w_accept;
   assign rom_addr      = flash_mem_address;
   assign pending_count = r_pending;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tog     <= 1'b0;
         r_acc_d   <= 1'b0;
         r_pending <= '0;
      end else begin
         r_tog   <= throttle & ~r_tog;
         r_acc_d <= w_accept;
         case ({w_accept, flash_mem_readdatavalid})
            2'b10:   r_pending <= r_pending + ONE;
            2'b01:   r_pending <= r_pending - ONE;
            default: r_pending <= r_pending;
         endcase
      end
   end

   // ROM data arrives one cycle after accept, aligned with r_acc_d; LATENCY-1 stages reach the outputs.
   flash_resp_pipe #(
      .DEPTH  (LATENCY-1),
      .DATA_W (FLASH_DATA_W)
   ) u_pipe (
      .clk     (clk),
      .rst     (reset),
      .i_valid (r_acc_d),
      .i_data  (rom_q),
      .o_valid (flash_mem_readdatavalid),
      .o_data  (flash_mem_readdata)
   );

endmodule

// File: tb/tb_flash_read_responder.sv
// Self-checking bench for flash_read_responder: scoreboard model plus directed literal checks.
module tb_flash_read_responder;

   localparam int LAT = 4;
   localparam int MP  = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        read, waitreq, valid, throttle, rom_rd;
   logic [20:0] addr, rom_addr;
   logic [31:0] data, rom_q;
   logic [2:0]  pend;

   logic        read2, waitreq2, valid2, throttle2, rom_rd2;
   logic [20:0] addr2, rom_addr2;
   logic [31:0] data2, rom_q2;
   logic [3:0]  pend2;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   flash_read_responder #(.ADDR_W(21), .LATENCY(LAT), .MAX_PENDING(MP)) u_dut (
      .clk(clk), .reset(reset), .flash_mem_read(read), .flash_mem_address(addr),
      .flash_mem_waitrequest(waitreq), .flash_mem_readdatavalid(valid),
      .flash_mem_readdata(data), .throttle(throttle), .rom_rd(rom_rd),
      .rom_addr(rom_addr), .rom_q(rom_q), .pending_count(pend));

   flash_read_responder #(.ADDR_W(21), .LATENCY(LAT), .MAX_PENDING(8)) u_dut8 (
      .clk(clk), .reset(reset), .flash_mem_read(read2), .flash_mem_address(addr2),
      .flash_mem_waitrequest(waitreq2), .flash_mem_readdatavalid(valid2),
      .flash_mem_readdata(data2), .throttle(throttle2), .rom_rd(rom_rd2),
      .rom_addr(rom_addr2), .rom_q(rom_q2), .pending_count(pend2));

   function automatic logic [31:0] rom_val(input logic [20:0] a);
      if (a == 21'h10)     return 32'hDEADBEEF;
      if (a == 21'h1FFFFF) return 32'hA5A55A5A;
      return (32'(a) * 32'h9E3779B1) + 32'h13579BDF;
   endfunction

   always @(posedge clk) if (rom_rd)  rom_q  <= rom_val(rom_addr);
   always @(posedge clk) if (rom_rd2) rom_q2 <= rom_val(rom_addr2);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard model: each accepted read must come back exactly LAT cycles later.
   typedef struct { int due; logic [31:0] d; } resp_t;
   resp_t       q[$];
   int          m_pend = 0;
   logic        m_tog  = 1'b0;
   logic        exp_v, exp_w, m_acc;
   logic [31:0] exp_d;

   always @(negedge clk) begin
      if (reset) begin
         q.delete();
         m_pend = 0;
         m_tog  = 1'b0;
         chk("m_rst_valid", 32'(valid), 0);
         chk("m_rst_data", data, 0);
         chk("m_rst_pend", 32'(pend), 0);
         chk("m_rst_wait", 32'(waitreq), 0);
         chk("m_rst_romrd", 32'(rom_rd), 0);
      end else begin
         exp_v = (q.size() > 0) && (q[0].due == cyc);
         exp_d = exp_v ? q[0].d : 32'h0;
         if (exp_v) void'(q.pop_front());
         exp_w = (m_pend == MP) || (throttle && m_tog);
         chk("m_valid", 32'(valid), 32'(exp_v));
         chk("m_data", data, exp_d);
         chk("m_pend", 32'(pend), 32'(m_pend));
         chk("m_wait", 32'(waitreq), 32'(exp_w));
         m_acc = read && !exp_w;
         chk("m_romrd", 32'(rom_rd), 32'(m_acc));
         if (m_acc) begin
            chk("m_romaddr", 32'(rom_addr), 32'(addr));
            q.push_back('{due: cyc + LAT, d: rom_val(addr)});
         end
         m_pend = m_pend + int'(m_acc) - int'(exp_v);
         m_tog  = throttle ? !m_tog : 1'b0;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle;
      logic done;
      done = 1'b0;
      for (int i = 0; i < 64 && !done; i++) begin
         @(negedge clk);
         done = (pend == 0) && (q.size() == 0);
         tick();
      end
      chk("idle_timeout", 32'(done), 1);
   endtask

   int exp_resp[6] = '{4, 5, 6, 7, 9, 10};
   int idx, nresp, acc, cnt;

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; read = 1'b0; addr = '0; throttle = 1'b0;
      read2 = 1'b0; addr2 = '0; throttle2 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(valid), 0);
      chk("rst_pend", 32'(pend), 0);
      chk("rst_wait", 32'(waitreq), 0);
      tick();
      reset = 1'b0;
      repeat (3) tick();

      // Single read at 0x10
      read = 1'b1; addr = 21'h10;
      @(negedge clk);
      chk("single_wait", 32'(waitreq), 0);
      chk("single_romrd", 32'(rom_rd), 1);
      chk("single_romaddr", 32'(rom_addr), 32'h10);
      tick();
      read = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         chk("single_valid", 32'(valid), (k == 4) ? 32'd1 : 32'd0);
         chk("single_data", data, (k == 4) ? 32'hDEADBEEF : 32'h0);
         chk("single_pend", 32'(pend), (k <= 4) ? 32'd1 : 32'd0);
         tick();
      end
      wait_idle();

      // Full outstanding window
      idx = 0; nresp = 0;
      for (int rel = 0; rel < 14; rel++) begin
         read = (idx < 6);
         addr = 21'(idx);
         @(negedge clk);
         if (rel <= 6) chk("win_wait", 32'(waitreq), (rel == 4) ? 32'd1 : 32'd0);
         if (valid) begin
            if (nresp < 6) chk("win_resp_cycle", 32'(rel), 32'(exp_resp[nresp]));
            chk("win_resp_data", data, rom_val(21'(nresp)));
            nresp++;
         end
         if (read && !waitreq) idx++;
         tick();
      end
      read = 1'b0;
      chk("win_resp_count", 32'(nresp), 6);
      wait_idle();

      // Reset with three reads in flight
      for (int i = 0; i < 3; i++) begin
         read = 1'b1; addr = 21'(32'h20 + i);
         tick();
      end
      read = 1'b1; addr = 21'h25;
      reset = 1'b1;
      #1;
      chk("midrst_valid", 32'(valid), 0);
      chk("midrst_data", data, 0);
      chk("midrst_pend", 32'(pend), 0);
      chk("midrst_romrd", 32'(rom_rd), 0);
      tick();
      tick();
      reset = 1'b0; read = 1'b0;
      cnt = 0;
      for (int i = 0; i < 2 * LAT; i++) begin
         @(negedge clk);
         cnt += int'(valid);
         tick();
      end
      chk("stale_after_rst", 32'(cnt), 0);
      read = 1'b1; addr = 21'h30;
      tick();
      read = 1'b0;
      for (int k = 1; k <= LAT; k++) begin
         @(negedge clk);
         chk("postrst_valid", 32'(valid), (k == LAT) ? 32'd1 : 32'd0);
         if (k == LAT) chk("postrst_data", data, rom_val(21'h30));
         tick();
      end
      wait_idle();

      // Throttle: accepts on alternate cycles starting immediately
      throttle = 1'b1; read = 1'b1; acc = 0;
      for (int rel = 0; rel < 8; rel++) begin
         addr = 21'(32'h40 + rel);
         @(negedge clk);
         chk("thr_wait", 32'(waitreq), 32'(rel % 2));
         if (!waitreq) acc++;
         tick();
      end
      throttle = 1'b0; read = 1'b0;
      @(negedge clk);
      chk("thr_off_wait", 32'(waitreq), 0);
      tick();
      chk("thr_accepts", 32'(acc), 4);
      wait_idle();

      // Top address
      read = 1'b1; addr = 21'h1FFFFF;
      @(negedge clk);
      chk("top_romrd", 32'(rom_rd), 1);
      chk("top_romaddr", 32'(rom_addr), 32'h1FFFFF);
      tick();
      read = 1'b0;
      repeat (LAT - 1) tick();
      @(negedge clk);
      chk("top_valid", 32'(valid), 1);
      chk("top_data", data, 32'hA5A55A5A);
      tick();
      wait_idle();

      // MAX_PENDING=8: accept and response in the same cycle keep the count at LAT
      read2 = 1'b1;
      for (int rel = 0; rel < 20; rel++) begin
         addr2 = 21'(rel);
         @(negedge clk);
         chk("d8_wait", 32'(waitreq2), 0);
         chk("d8_pend", 32'(pend2), (rel < LAT) ? 32'(rel) : 32'(LAT));
         chk("d8_valid", 32'(valid2), (rel >= LAT) ? 32'd1 : 32'd0);
         if (rel >= LAT) chk("d8_data", data2, rom_val(21'(rel - LAT)));
         tick();
      end
      read2 = 1'b0;
      repeat (LAT + 2) tick();
      chk("d8_drain_pend", 32'(pend2), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
